// File: rtl/uart_axi_pkg.sv
// Shared opcodes, FSM state type and response-byte helper for the UART-driven
// AXI4-Lite command master.
package uart_axi_pkg;

   localparam logic [7:0] OP_WR     = 8'h57;
   localparam logic [7:0] OP_RD     = 8'h52;
   localparam logic [7:0] RSP_BADOP = 8'hFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_WDATA,
      ST_AW_W,
      ST_B,
      ST_AR,
      ST_R,
      ST_RESP
   } axi_mst_state_e;

   function automatic logic [7:0] status_byte(input logic [1:0] resp);
      return {6'b000000, resp};
   endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bus bundle with 32-bit address and data; M is the initiator view.
interface axi4_lite_if;

   logic [31:0] awaddr;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [31:0] araddr;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   modport M (
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input bresp, bvalid, output bready,
      output araddr, arprot, arvalid, input arready,
      input rdata, rresp, rvalid, output rready
   );

   modport S (
      input awaddr, awprot, awvalid, output awready,
      input wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );

endinterface

// File: rtl/uart_axi_resp.sv
// Load-then-shift response serialiser: up to 5 bytes, LSB first, onto a
// valid/ready byte stream. done is high in the cycle of the final transfer.
module uart_axi_resp (
   input  logic        clk,
   input  logic        rstn,
   input  logic        load,
   input  logic [2:0]  len,
   input  logic [39:0] data,
   input  logic        tx_ready,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   output logic        done
);

   logic [31:0] rest_reg;
   logic [2:0]  left_reg;

   assign done = tx_valid & tx_ready & (left_reg == 3'd1);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         tx_valid <= 1'b0;
         tx_data  <= 8'h00;
         rest_reg <= 32'h0;
         left_reg <= 3'd0;
      end else if (load) begin
         tx_valid <= 1'b1;
         tx_data  <= data[7:0];
         rest_reg <= data[39:8];
         left_reg <= len;
      end else if (tx_valid && tx_ready) begin
         tx_data  <= rest_reg[7:0];
         rest_reg <= {8'h00, rest_reg[31:8]};
         left_reg <= left_reg - 3'd1;
         if (left_reg == 3'd1) begin
            tx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/uart_axi_master.sv
// Parses serial read/write commands, runs one AXI4-Lite transaction per
// command and streams back the status (and read data) bytes.
module uart_axi_master
   import uart_axi_pkg::*;
#(
   parameter int TIMEOUT = 208334
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        i_rx_valid,
   input  logic [7:0]  i_rx_data,
   output logic        o_tx_valid,
   input  logic        i_tx_ready,
   output logic [7:0]  o_tx_data,
   output logic        o_drop,
   axi4_lite_if.M      axi
);

   localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   axi_mst_state_e  state_reg;
   logic [1:0]      cnt_reg;
   logic [TO_W-1:0] to_cnt_reg;
   logic            is_wr_reg;
   logic [31:0]     addr_reg;
   logic [31:0]     wdata_reg;
   logic            awvalid_reg, wvalid_reg, bready_reg, arvalid_reg, rready_reg;

   logic            rsp_load;
   logic [2:0]      rsp_len;
   logic [39:0]     rsp_data;
   logic            rsp_done;
   logic            is_op;
   logic            to_hit;
   logic            aw_left, w_left;

   assign is_op   = (i_rx_data == OP_WR) || (i_rx_data == OP_RD);
   assign to_hit  = (to_cnt_reg == TO_W'(TIMEOUT - 1));
   assign aw_left = awvalid_reg & ~axi.awready;
   assign w_left  = wvalid_reg & ~axi.wready;

   assign o_drop = rstn & i_rx_valid &
                   (state_reg != ST_IDLE) & (state_reg != ST_ADDR) & (state_reg != ST_WDATA);

   assign axi.awaddr  = addr_reg;
   assign axi.awprot  = 3'b000;
   assign axi.awvalid = awvalid_reg;
   assign axi.wdata   = wdata_reg;
   assign axi.wstrb   = 4'hF;
   assign axi.wvalid  = wvalid_reg;
   assign axi.bready  = bready_reg;
   assign axi.araddr  = addr_reg;
   assign axi.arprot  = 3'b000;
   assign axi.arvalid = arvalid_reg;
   assign axi.rready  = rready_reg;

   // The serialiser loads straight off the bus in the handshake cycle so the
   // first response byte is valid one cycle after B/R completes.
   always_comb begin
      rsp_load = 1'b0;
      rsp_len  = 3'd1;
      rsp_data = {32'h0, RSP_BADOP};
      case (state_reg)
         ST_IDLE: rsp_load = i_rx_valid & ~is_op;
         ST_B: begin
            rsp_load = axi.bvalid;
            rsp_data = {32'h0, status_byte(axi.bresp)};
         end
         ST_R: begin
            rsp_load = axi.rvalid;
            rsp_len  = 3'd5;
            rsp_data = {axi.rdata, status_byte(axi.rresp)};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_reg   <= ST_IDLE;
         cnt_reg     <= 2'd0;
         to_cnt_reg  <= '0;
         is_wr_reg   <= 1'b0;
         addr_reg    <= 32'h0;
         wdata_reg   <= 32'h0;
         awvalid_reg <= 1'b0;
         wvalid_reg  <= 1'b0;
         bready_reg  <= 1'b0;
         arvalid_reg <= 1'b0;
         rready_reg  <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (i_rx_valid) begin
                  cnt_reg    <= 2'd0;
                  to_cnt_reg <= '0;
                  if (is_op) begin
                     is_wr_reg <= (i_rx_data == OP_WR);
                     state_reg <= ST_ADDR;
                  end else begin
                     state_reg <= ST_RESP;
                  end
               end
            end
            ST_ADDR: begin
               if (i_rx_valid) begin
                  addr_reg[{cnt_reg, 3'b000} +: 8] <= i_rx_data;
                  cnt_reg    <= cnt_reg + 2'd1;
                  to_cnt_reg <= '0;
                  if (cnt_reg == 2'd3) begin
                     if (is_wr_reg) begin
                        state_reg <= ST_WDATA;
                     end else begin
                        arvalid_reg <= 1'b1;
                        state_reg   <= ST_AR;
                     end
                  end
               end else if (to_hit) begin
                  state_reg <= ST_IDLE;
               end else begin
                  to_cnt_reg <= to_cnt_reg + 1'b1;
               end
            end
            ST_WDATA: begin
               if (i_rx_valid) begin
                  wdata_reg[{cnt_reg, 3'b000} +: 8] <= i_rx_data;
                  cnt_reg    <= cnt_reg + 2'd1;
                  to_cnt_reg <= '0;
                  if (cnt_reg == 2'd3) begin
                     awvalid_reg <= 1'b1;
                     wvalid_reg  <= 1'b1;
                     state_reg   <= ST_AW_W;
                  end
               end else if (to_hit) begin
                  state_reg <= ST_IDLE;
               end else begin
                  to_cnt_reg <= to_cnt_reg + 1'b1;
               end
            end
            ST_AW_W: begin
               awvalid_reg <= aw_left;
               wvalid_reg  <= w_left;
               if (!aw_left && !w_left) begin
                  bready_reg <= 1'b1;
                  state_reg  <= ST_B;
               end
            end
            ST_B: begin
               if (axi.bvalid) begin
                  bready_reg <= 1'b0;
                  state_reg  <= ST_RESP;
               end
            end
            ST_AR: begin
               if (axi.arready) begin
                  arvalid_reg <= 1'b0;
                  rready_reg  <= 1'b1;
                  state_reg   <= ST_R;
               end
            end
            ST_R: begin
               if (axi.rvalid) begin
                  rready_reg <= 1'b0;
                  state_reg  <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (rsp_done) begin
                  state_reg <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   uart_axi_resp u_resp (
      .clk      (clk),
      .rstn     (rstn),
      .load     (rsp_load),
      .len      (rsp_len),
      .data     (rsp_data),
      .tx_ready (i_tx_ready),
      .tx_valid (o_tx_valid),
      .tx_data  (o_tx_data),
      .done     (rsp_done)
   );

endmodule

// File: tb/tb_uart_axi_master.sv
// Directed bench for uart_axi_master: a small AXI4-Lite slave model plus a
// bus/stream monitor, with hand-computed expectations per command.
module tb_uart_axi_master;

   localparam int TO = 40;

   logic       clk = 1'b0;
   logic       rstn;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] tx_data;
   logic       drop;

   axi4_lite_if axi_bus ();

   uart_axi_master #(.TIMEOUT(TO)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .i_rx_valid (rx_valid),
      .i_rx_data  (rx_data),
      .o_tx_valid (tx_valid),
      .i_tx_ready (tx_ready),
      .o_tx_data  (tx_data),
      .o_drop     (drop),
      .axi        (axi_bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // slave configuration
   int          aw_delay = 0;
   int          w_delay  = 0;
   logic [1:0]  cfg_bresp = 2'b00;
   logic [1:0]  cfg_rresp = 2'b00;
   logic [31:0] cfg_rdata = 32'h0;
   bit          tx_toggle = 1'b0;

   // monitor state
   int cyc = 0, aw_wait = 0, w_wait = 0;
   int aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, act_n = 0, drop_n = 0;
   int aw_cyc = 0, w_cyc = 0;
   int order_viol = 0, lat_viol = 0, hold_viol = 0, stall_viol = 0;
   bit aw_ok = 0, w_ok = 0, ar_ok = 0, b_fire = 0, r_fire = 0, resp_pend = 0;
   logic [31:0] cap_awaddr = 0, cap_wdata = 0, cap_araddr = 0;
   logic [3:0]  cap_wstrb = 0;
   logic        p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
   logic        p_txv = 0, p_txr = 0;
   logic [7:0]  p_txd = 0;
   logic [7:0]  tx_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Slave responses and monitoring, sampled mid-cycle; fire flags refer to
   // the handshake at the next rising edge.
   initial begin : slave_mon
      forever begin
         @(negedge clk);
         #2;
         if (tx_toggle) tx_ready = ~tx_ready;
         if (b_fire) axi_bus.bvalid = 1'b0;
         else if (aw_ok && w_ok && !axi_bus.bvalid) begin
            axi_bus.bvalid = 1'b1;
            axi_bus.bresp  = cfg_bresp;
            aw_ok = 0;
            w_ok  = 0;
         end
         if (r_fire) axi_bus.rvalid = 1'b0;
         else if (ar_ok && !axi_bus.rvalid) begin
            axi_bus.rvalid = 1'b1;
            axi_bus.rdata  = cfg_rdata;
            axi_bus.rresp  = cfg_rresp;
            ar_ok = 0;
         end
         axi_bus.awready = axi_bus.awvalid && (aw_wait >= aw_delay);
         aw_wait = axi_bus.awvalid ? aw_wait + 1 : 0;
         axi_bus.wready = axi_bus.wvalid && (w_wait >= w_delay);
         w_wait = axi_bus.wvalid ? w_wait + 1 : 0;
         axi_bus.arready = axi_bus.arvalid;

         if (axi_bus.bready && (aw_n <= b_n || w_n <= b_n)) order_viol++;
         if (resp_pend && !tx_valid) lat_viol++;
         resp_pend = 0;
         if (p_awv && !p_awr && !axi_bus.awvalid) hold_viol++;
         if (p_wv && !p_wr && !axi_bus.wvalid) hold_viol++;
         if (p_arv && !p_arr && !axi_bus.arvalid) hold_viol++;
         if (axi_bus.awvalid && axi_bus.awready) begin
            aw_ok = 1; aw_n++; aw_cyc = cyc; cap_awaddr = axi_bus.awaddr;
         end
         if (axi_bus.wvalid && axi_bus.wready) begin
            w_ok = 1; w_n++; w_cyc = cyc; cap_wdata = axi_bus.wdata; cap_wstrb = axi_bus.wstrb;
         end
         b_fire = axi_bus.bvalid && axi_bus.bready;
         if (b_fire) begin b_n++; resp_pend = 1; end
         if (axi_bus.arvalid && axi_bus.arready) begin
            ar_ok = 1; ar_n++; cap_araddr = axi_bus.araddr;
         end
         r_fire = axi_bus.rvalid && axi_bus.rready;
         if (r_fire) resp_pend = 1;
         if (axi_bus.awvalid || axi_bus.wvalid || axi_bus.arvalid) act_n++;
         if (tx_valid && tx_ready) tx_q.push_back(tx_data);
         if (p_txv && !p_txr && (!tx_valid || tx_data != p_txd)) stall_viol++;
         if (drop) drop_n++;
         p_awv = axi_bus.awvalid; p_awr = axi_bus.awready;
         p_wv = axi_bus.wvalid;   p_wr = axi_bus.wready;
         p_arv = axi_bus.arvalid; p_arr = axi_bus.arready;
         p_txv = tx_valid; p_txr = tx_ready; p_txd = tx_data;
         cyc++;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      #1;
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_cmd(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data);
      send_byte(op);
      for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
      if (op == 8'h57) for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8]);
   endtask

   task automatic wait_tx(input string tag, input int n);
      int k = 0;
      while (tx_q.size() < n && k < 200) begin
         @(negedge clk);
         k++;
      end
      check(tag, tx_q.size(), n);
      repeat (3) @(negedge clk);
   endtask

   function automatic logic [39:0] pack_q();
      logic [39:0] v = '0;
      foreach (tx_q[i]) v = {v[31:0], tx_q[i]};
      return v;
   endfunction

   initial begin : main
      int a0, d0, k;
      rstn = 1'b0;
      rx_valid = 1'b0;
      rx_data = 8'h00;
      tx_ready = 1'b1;
      axi_bus.awready = 0; axi_bus.wready = 0; axi_bus.arready = 0;
      axi_bus.bvalid = 0; axi_bus.bresp = 0;
      axi_bus.rvalid = 0; axi_bus.rresp = 0; axi_bus.rdata = 0;
      repeat (4) @(negedge clk);
      #1;
      check("rst_ctrl", {axi_bus.awvalid, axi_bus.wvalid, axi_bus.bready,
                         axi_bus.arvalid, axi_bus.rready, tx_valid, drop}, 7'h00);
      check("rst_tx_data", tx_data, 8'h00);
      check("rst_addr", {axi_bus.awaddr, axi_bus.araddr}, 64'h0);
      check("rst_wdata", axi_bus.wdata, 32'h0);
      rstn = 1'b1;
      repeat (2) @(negedge clk);

      // 1: plain write, OKAY
      tx_q.delete();
      cfg_bresp = 2'b00;
      send_byte(8'h57);
      send_byte(8'h10); send_byte(8'h00); send_byte(8'h00); send_byte(8'h40);
      send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
      check("wr_valid_lat", {axi_bus.awvalid, axi_bus.wvalid}, 2'b11);
      wait_tx("wr_tx_cnt", 1);
      check("wr_awaddr", cap_awaddr, 32'h4000_0010);
      check("wr_wdata", cap_wdata, 32'hDEAD_BEEF);
      check("wr_wstrb", cap_wstrb, 4'hF);
      check("wr_tx", pack_q(), 40'h00);
      $display("txn write addr=%h data=%h tx=%h", cap_awaddr, cap_wdata, pack_q());

      // 2: plain read
      tx_q.delete();
      cfg_rdata = 32'h1234_5678; cfg_rresp = 2'b00;
      send_cmd(8'h52, 32'h0000_0004, 32'h0);
      check("rd_valid_lat", axi_bus.arvalid, 1'b1);
      wait_tx("rd_tx_cnt", 5);
      check("rd_araddr", cap_araddr, 32'h4);
      check("rd_tx", pack_q(), 40'h00_78_56_34_12);
      $display("txn read addr=%h tx=%h", cap_araddr, pack_q());

      // 3: write, AWREADY late, SLVERR
      tx_q.delete();
      aw_delay = 5; w_delay = 0; cfg_bresp = 2'b10;
      send_cmd(8'h57, 32'h0000_0100, 32'h0BAD_F00D);
      wait_tx("wr2_tx_cnt", 1);
      check("wr2_aw_after_w", aw_cyc - w_cyc, 5);
      check("wr2_awaddr", cap_awaddr, 32'h100);
      check("wr2_wdata", cap_wdata, 32'h0BAD_F00D);
      check("wr2_tx", pack_q(), 40'h02);
      aw_delay = 0;
      $display("txn write-late addr=%h data=%h tx=%h", cap_awaddr, cap_wdata, pack_q());

      // 4: unknown opcode, then a normal read
      tx_q.delete();
      a0 = act_n;
      send_byte(8'h41);
      wait_tx("bad_tx_cnt", 1);
      check("bad_tx", pack_q(), 40'hFF);
      check("bad_no_axi", act_n - a0, 0);
      $display("txn badop tx=%h", pack_q());
      tx_q.delete();
      cfg_rdata = 32'hA5A5_0001; cfg_rresp = 2'b00;
      send_cmd(8'h52, 32'h0000_0008, 32'h0);
      wait_tx("rd2_tx_cnt", 5);
      check("rd2_araddr", cap_araddr, 32'h8);
      check("rd2_tx", pack_q(), 40'h00_01_00_A5_A5);
      $display("txn read addr=%h tx=%h", cap_araddr, pack_q());

      // 5: abandoned write, then a fresh read parsed from scratch
      tx_q.delete();
      a0 = act_n;
      send_byte(8'h57); send_byte(8'h10); send_byte(8'h00);
      repeat (TO + 4) @(negedge clk);
      check("to_no_tx", tx_q.size(), 0);
      check("to_no_axi", act_n - a0, 0);
      cfg_rdata = 32'hCAFE_F00D; cfg_rresp = 2'b01;
      send_cmd(8'h52, 32'h0000_000C, 32'h0);
      wait_tx("to_rd_tx_cnt", 5);
      check("to_rd_araddr", cap_araddr, 32'hC);
      check("to_rd_tx", pack_q(), 40'h01_0D_F0_FE_CA);
      $display("txn timeout-then-read addr=%h tx=%h", cap_araddr, pack_q());

      // 5b: gaps just below the timeout keep the command alive
      tx_q.delete();
      cfg_rdata = 32'h0000_00C3; cfg_rresp = 2'b00;
      send_byte(8'h52);
      repeat (TO - 6) @(negedge clk);
      send_byte(8'h18);
      repeat (TO - 6) @(negedge clk);
      send_byte(8'h00); send_byte(8'h00);
      repeat (TO - 6) @(negedge clk);
      send_byte(8'h00);
      wait_tx("slow_tx_cnt", 5);
      check("slow_araddr", cap_araddr, 32'h18);
      check("slow_tx", pack_q(), 40'h00_C3_00_00_00);
      $display("txn slow-read addr=%h tx=%h", cap_araddr, pack_q());

      // 6: stalled response with stray bytes arriving mid-response
      tx_q.delete();
      d0 = drop_n;
      cfg_rdata = 32'h89AB_CDEF; cfg_rresp = 2'b00;
      tx_toggle = 1'b1;
      send_cmd(8'h52, 32'h0000_0010, 32'h0);
      k = 0;
      while (!tx_valid && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("stall_resp_start", tx_valid, 1'b1);
      send_byte(8'hAA); send_byte(8'h57); send_byte(8'h52);
      wait_tx("stall_tx_cnt", 5);
      tx_toggle = 1'b0;
      tx_ready = 1'b1;
      check("stall_tx", pack_q(), 40'h00_EF_CD_AB_89);
      check("stall_drops", drop_n - d0, 3);
      $display("txn stalled-read addr=%h tx=%h drops=%0d", cap_araddr, pack_q(), drop_n - d0);

      tx_q.delete();
      cfg_rdata = 32'h0BAD_BEEF;
      send_cmd(8'h52, 32'h0000_0014, 32'h0);
      wait_tx("post_tx_cnt", 5);
      check("post_araddr", cap_araddr, 32'h14);
      check("post_tx", pack_q(), 40'h00_EF_BE_AD_0B);
      $display("txn read addr=%h tx=%h", cap_araddr, pack_q());

      check("bready_order", order_viol, 0);
      check("resp_latency", lat_viol, 0);
      check("valid_hold", hold_viol, 0);
      check("tx_stable", stall_viol, 0);
      check("handshake_counts", {aw_n[15:0], w_n[15:0], b_n[15:0], ar_n[15:0]},
            {16'd2, 16'd2, 16'd2, 16'd6});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_axi_master.md
# uart_axi_master

Command-driven AXI4-Lite initiator that lets a host on the serial link read and write any register on the on-chip AXI4-Lite fabric, including the UART peripheral's own register file. It consumes bytes from the `uart_rx` output (valid pulse, no backpressure) and parses fixed-format read/write commands. For each command it issues one AXI4-Lite transaction and returns the status and read data as bytes on a valid/ready stream into `uart_tx`. It sits between `uart_rx`/`uart_tx` (or their FIFOs) and the fabric's master port.

## Interface
- `TIMEOUT`, 208334, inter-byte timeout in clk cycles; an incomplete command is abandoned after this.
- AXI address and data widths are fixed at 32 bits.
- `clk`  in  1  system clock
- `rstn`  in  1  reset; synchronous, active-low
- `i_rx_valid`  in  1  one-cycle pulse: received byte available
- `i_rx_data`  in  8  received byte
- `o_tx_valid`  out  1  response byte valid
- `i_tx_ready`  in  1  transmitter accepts the byte
- `o_tx_data`  out  8  response byte
- `o_drop`  out  1  one-cycle pulse: received byte discarded while busy
- `axi`  modport  `axi4_lite_if.M`  AXI4-Lite master

## Operation
- Command formats; all multi-byte fields are little-endian:
  - write: `0x57`, addr[4], data[4]
  - read: `0x52`, addr[4]
- Any other first byte is an unknown opcode. It is consumed and answered with the single byte `0xFF`.
- State machine:
  - IDLE → ADDR on a valid opcode; IDLE → RESP on an unknown opcode.
  - ADDR collects 4 bytes. After the 4th byte: write → WDATA, read → AR.
  - WDATA collects 4 bytes, then → AW_W.
  - AW_W: AWVALID and WVALID are raised together. Each drops independently on its own handshake. When both are done → B.
  - B: BREADY=1; on the handshake, latch bresp → RESP.
  - AR: ARVALID until ARREADY → R.
  - R: RREADY=1; on the handshake, latch rresp and rdata → RESP.
  - RESP serialises the response, then → IDLE.
- Response bytes:
  - write: one byte, `{6'b0, bresp}`.
  - read: `{6'b0, rresp}` followed by rdata bytes 0..3, LSB first.
  - Read data is sent even when rresp is not OKAY.
- Fixed AXI fields: WSTRB=4'hF, AWPROT=ARPROT=3'b000.
- Byte counter: 2 bits, cleared on entering ADDR or WDATA, wraps 3→0 on the transition out.
- Timeout:
  - A counter runs in ADDR and WDATA only. It clears on every accepted byte.
  - On reaching TIMEOUT-1 the state goes to IDLE with no response and no AXI activity.
- Bytes arriving in AW_W, B, AR, R or RESP are discarded and pulse `o_drop` in the same cycle as `i_rx_valid`.

## Timing
- Reset values:
  - o_tx_valid=0, o_tx_data=0, o_drop=0.
  - All AXI VALID and READY outputs 0; AXI address and data outputs 0.
  - State IDLE, counters 0.
- Byte accepted at edge N (i_rx_valid sampled): the state and counter update at N. The final command byte at edge N gives AWVALID/WVALID or ARVALID high during cycle N+1.
- A VALID, once high, holds along with its payload until the matching READY, per AXI. No combinational path from READY to VALID.
- AWREADY and WREADY may arrive in the same cycle or in either order. BREADY rises only after both handshakes are complete.
- B or R handshake at edge M: o_tx_valid=1 with the first response byte during cycle M+1.
- TX stream:
  - A byte transfers on o_tx_valid & i_tx_ready.
  - o_tx_data is stable while o_tx_valid=1 and ready=0.
  - The next byte is presented the cycle after a transfer. o_tx_valid stays high between bytes of one response when ready is held high.
  - On the final transfer, o_tx_valid=0 and the state is IDLE on the next cycle.
- Minimum command-to-command spacing: none beyond the response draining. A byte arriving in the cycle RESP exits is dropped.
- Reset mid-operation: all outputs return to reset values at the next edge. Partial commands and responses are lost. The fabric is reset on the same `rstn`.

## Structure
- Package `uart_axi_pkg`:
  - opcode constants `OP_WR`=8'h57, `OP_RD`=8'h52, `RSP_BADOP`=8'hFF
  - state enum `axi_mst_state_e`
- One sub-module: `uart_axi_resp`, a 5-byte load-then-shift serialiser with a length input (1 or 5). It drives o_tx_valid/o_tx_data and returns done.
- Address, data and response registers live in the top module.

## Test plan
- Write 57 10 00 00 40 EF BE AD DE, slave OKAY → AWADDR=0x4000_0010, WDATA=0xDEADBEEF, WSTRB=F; TX byte 0x00.
- Read 52 04 00 00 00, slave returns 0x12345678 OKAY → ARADDR=0x4; TX 00 78 56 34 12.
- Write with AWREADY 5 cycles late and WREADY immediate, slave returns SLVERR → both VALIDs hold until accepted, BREADY only after both; TX 0x02.
- Byte 0x41 → TX 0xFF, no AXI activity; then a valid read completes normally.
- 57 plus 2 address bytes, then silence for TIMEOUT cycles → return to IDLE, no TX. The next 52 command is parsed from scratch.
- Read with i_tx_ready toggling and extra RX bytes mid-response → TX data stable while stalled, 5 bytes in order, o_drop pulses once per extra byte.
